// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares one single-port, fixed-latency memory between the pipeline's IF
// stage (read-only fetch) and MEM stage (load/store).  One requester is
// granted at a time.  The command is held on the RAM port for LATENCY cycles.
// The read data is captured on the last of those cycles and returned with a
// one-cycle ack.  Each access walks IDLE -> ACCESS -> RESP -> IDLE, so it
// occupies LATENCY+2 cycles from the request being seen to the ack.
//
// Arbitration: MEM beats IF, because MEM holds the older instruction.
//
// Optional feature (compile-time macro MEM_ARB_STARVE_GUARD_EN):
//   A starve counter counts the IDLE arbitrations that IF loses to MEM.
//   Once the counter reaches STARVE_LIMIT, IF wins the next arbitration.
//   The counter clears whenever IF is granted.  With the macro undefined,
//   MEM has fixed priority and no counter logic is built.
//
// Parameters
//   ADDR_W        address width, both requesters and memory
//   DATA_W        data width
//   LATENCY       cycles a command is held on the RAM port (>= 1)
//   STARVE_LIMIT  IF losses before IF is forced to win (guard build only)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   if_req_i     fetch request, held until if_ack_o
//   if_addr_i    fetch address
//   if_rdata_o   fetched word, held until the next IF ack
//   if_ack_o     one-cycle IF completion pulse
//   mem_req_i    load/store request, held until mem_ack_o
//   mem_we_i     1 = store, 0 = load
//   mem_addr_i   load/store address
//   mem_wdata_i  store data
//   mem_rdata_o  load data, held until the next MEM ack
//   mem_ack_o    one-cycle MEM completion pulse
//   stall_if_o   if_req_i & ~if_ack_o
//   stall_mem_o  mem_req_i & ~mem_ack_o
//   ram_en_o     RAM command valid
//   ram_we_o     RAM write enable, only high together with ram_en_o
//   ram_addr_o   RAM address, registered from the granted requester
//   ram_wdata_o  RAM write data
//   ram_rdata_i  RAM read data, sampled on the last ACCESS cycle
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    // The countdown only has to hold LATENCY-1.  It keeps at least one bit
    // so that LATENCY=1 still elaborates.
    localparam int CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    // Reject parameter values that cannot describe a real memory or guard.
    if (LATENCY < 1 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("mem_port_arbiter: LATENCY and STARVE_LIMIT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             grant_if;
    logic             grant_mem;
    logic             is_store;
    logic             pick_if;
    logic             pick_mem;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] starve_cnt;
    logic                force_if;
`endif

    // Pick the winner of an IDLE arbitration.  MEM wins by default.  In the
    // guard build, a starved IF that is still requesting takes the slot.
    always_comb begin
        pick_if  = 1'b0;
        pick_mem = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        force_if = if_req_i && (starve_cnt >= STARVE_W'(STARVE_LIMIT));
        pick_mem = mem_req_i && !force_if;
`else
        pick_mem = mem_req_i;
`endif
        pick_if  = if_req_i && !pick_mem;
    end

    // Main sequencer.
    //
    // Every RAM port signal and ack is a register, so the memory macro and
    // the pipeline only ever see glitch-free values.  The ack is raised on
    // the same edge that leaves ACCESS, which places it in the RESP cycle.
    // The default clear below then drops it one cycle later.  Reset aborts
    // any command in flight, and no ack follows it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            grant_if    <= 1'b0;
            grant_mem   <= 1'b0;
            is_store    <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt  <= '0;
`endif
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_mem || pick_if) begin
                        grant_mem   <= pick_mem;
                        grant_if    <= pick_if;
                        is_store    <= pick_mem && mem_we_i;
                        ram_en_o    <= 1'b1;
                        ram_we_o    <= pick_mem && mem_we_i;
                        ram_addr_o  <= pick_mem ? mem_addr_i : if_addr_i;
                        ram_wdata_o <= pick_mem ? mem_wdata_i : '0;
                        cnt         <= CNT_W'(LATENCY - 1);
                        state       <= ACCESS;
`ifdef MEM_ARB_STARVE_GUARD_EN
                        // Only a lost arbitration counts as starvation.
                        // An IF that is not requesting cannot starve.
                        if (pick_if) begin
                            starve_cnt <= '0;
                        end else if (if_req_i) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
`endif
                    end
                end

                ACCESS: begin
                    if (cnt == '0) begin
                        // Last command cycle: the RAM output is valid now.
                        // A store leaves the load data register untouched.
                        if (grant_if) begin
                            if_rdata_o <= ram_rdata_i;
                        end else if (!is_store) begin
                            mem_rdata_o <= ram_rdata_i;
                        end
                        if_ack_o  <= grant_if;
                        mem_ack_o <= grant_mem;
                        ram_en_o  <= 1'b0;
                        ram_we_o  <= 1'b0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                RESP: begin
                    // No arbitration here.  A loser waits for the next IDLE.
                    grant_if  <= 1'b0;
                    grant_mem <= 1'b0;
                    is_store  <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stalls must respond within the cycle so that the pipe registers freeze
    // on the very edge where a request is left waiting.
    assign stall_if_o  = if_req_i  & ~if_ack_o;
    assign stall_mem_o = mem_req_i & ~mem_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for mem_port_arbiter.
//
// A transaction-level model tracks the current access as "cycles since the
// grant" and keeps its own copy of memory contents.  Every cycle, the DUT
// outputs are compared against what that timeline implies.  Directed
// sequences pin the exact cycle positions and data values.  Randomized
// request traffic then exercises the rest.  A second instance with
// LATENCY=1 covers the shortest access.
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LAT   = 2;
    localparam int LIMIT = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic        d1_if_req = 1'b0;
    logic [31:0] d1_if_addr = '0;
    logic [31:0] d1_if_rdata;
    logic        d1_if_ack;
    logic        d1_mem_req = 1'b0;
    logic        d1_mem_we = 1'b0;
    logic [31:0] d1_mem_addr = '0;
    logic [31:0] d1_mem_wdata = '0;
    logic [31:0] d1_mem_rdata;
    logic        d1_mem_ack;
    logic        d1_stall_if;
    logic        d1_stall_mem;
    logic        d1_ram_en;
    logic        d1_ram_we;
    logic [31:0] d1_ram_addr;
    logic [31:0] d1_ram_wdata;
    logic [31:0] d1_ram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
        .stall_if_o(stall_if), .stall_mem_o(stall_mem),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .STARVE_LIMIT(LIMIT)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(d1_if_req), .if_addr_i(d1_if_addr), .if_rdata_o(d1_if_rdata), .if_ack_o(d1_if_ack),
        .mem_req_i(d1_mem_req), .mem_we_i(d1_mem_we), .mem_addr_i(d1_mem_addr), .mem_wdata_i(d1_mem_wdata),
        .mem_rdata_o(d1_mem_rdata), .mem_ack_o(d1_mem_ack),
        .stall_if_o(d1_stall_if), .stall_mem_o(d1_stall_mem),
        .ram_en_o(d1_ram_en), .ram_we_o(d1_ram_we), .ram_addr_o(d1_ram_addr), .ram_wdata_o(d1_ram_wdata),
        .ram_rdata_i(d1_ram_rdata)
    );

    // The LATENCY=1 instance sees a memory that returns address+1.
    assign d1_ram_rdata = {24'h0, d1_ram_addr[7:0]} + 32'd1;

    // Initial memory contents, keyed by the low address byte.  Location 0x10
    // holds the fetch word used by the directed lone-fetch case.
    function automatic logic [31:0] ram_init(input logic [7:0] idx);
        if (idx == 8'h10) return 32'hDEAD_BEEF;
        return ({24'h0, idx} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory macro stand-in: combinational read, written on each write cycle.
    logic [31:0] bram [0:255];
    logic        bram_written [0:255];
    initial for (int i = 0; i < 256; i++) bram_written[i] = 1'b0;
    assign ram_rdata = bram_written[ram_addr[7:0]] ? bram[ram_addr[7:0]] : ram_init(ram_addr[7:0]);
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            bram[ram_addr[7:0]]         <= ram_wdata;
            bram_written[ram_addr[7:0]] <= 1'b1;
        end
    end

    // Reference model.  m_t counts cycles since the grant: 0 = free,
    // 1..LAT = command on the RAM port, LAT+1 = ack cycle.
    int          m_t = 0;
    logic        m_g_mem = 1'b0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] e_if_rdata = '0;
    logic [31:0] e_mem_rdata = '0;
    int          m_starve = 0;
    logic [31:0] xmem [0:255];
    logic        xmem_written [0:255];
    initial for (int i = 0; i < 256; i++) xmem_written[i] = 1'b0;

    function automatic logic [31:0] model_read(input logic [7:0] idx);
        return xmem_written[idx] ? xmem[idx] : ram_init(idx);
    endfunction

    always @(posedge clk) begin
        logic take_mem;
        if (rst) begin
            m_t = 0; m_g_mem = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
            e_if_rdata = '0; e_mem_rdata = '0; m_starve = 0;
        end else if (m_t == 0) begin
            if (mem_req || if_req) begin
                take_mem = mem_req && !(GUARD && if_req && m_starve >= LIMIT);
                if (take_mem) begin
                    m_g_mem = 1'b1; m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
                    if (if_req) m_starve = m_starve + 1;
                end else begin
                    m_g_mem = 1'b0; m_we = 1'b0; m_addr = if_addr; m_wdata = '0;
                    m_starve = 0;
                end
                m_t = 1;
            end
        end else if (m_t == LAT + 1) begin
            m_t = 0;
        end else begin
            if (m_t == LAT) begin
                if (!m_g_mem) e_if_rdata = model_read(m_addr[7:0]);
                else if (!m_we) e_mem_rdata = model_read(m_addr[7:0]);
                else begin
                    xmem[m_addr[7:0]] = m_wdata;
                    xmem_written[m_addr[7:0]] = 1'b1;
                end
            end
            m_t = m_t + 1;
        end
    end

    task automatic check_word(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        logic e_en, e_we, e_if_ack, e_mem_ack;
        #2;
        e_en      = (m_t >= 1) && (m_t <= LAT);
        e_we      = e_en && m_g_mem && m_we;
        e_if_ack  = (m_t == LAT + 1) && !m_g_mem;
        e_mem_ack = (m_t == LAT + 1) && m_g_mem;
        check_bit("model_ram_en", ram_en, e_en);
        check_bit("model_ram_we", ram_we, e_we);
        if (e_en) check_word("model_ram_addr", ram_addr, m_addr);
        if (e_we) check_word("model_ram_wdata", ram_wdata, m_wdata);
        check_bit("model_if_ack", if_ack, e_if_ack);
        check_bit("model_mem_ack", mem_ack, e_mem_ack);
        check_word("model_if_rdata", if_rdata, e_if_rdata);
        check_word("model_mem_rdata", mem_rdata, e_mem_rdata);
        check_bit("model_stall_if", stall_if, if_req & ~e_if_ack);
        check_bit("model_stall_mem", stall_mem, mem_req & ~e_mem_ack);
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        return (r & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    // One cycle of random request traffic from both stages.  A pending
    // request is held until its ack.  Occasionally it is abandoned early.
    bit if_pend = 1'b0;
    bit mem_pend = 1'b0;
    task automatic apply_stimulus();
        if (if_pend) begin
            if (if_ack || $urandom_range(0, 99) < 3) begin
                if_pend = 1'b0; if_req = 1'b0;
            end
        end
        if (!if_pend && $urandom_range(0, 99) < 35) begin
            if_pend = 1'b1; if_req = 1'b1; if_addr = rand_addr();
        end
        if (mem_pend) begin
            if (mem_ack || $urandom_range(0, 99) < 3) begin
                mem_pend = 1'b0; mem_req = 1'b0;
            end
        end
        if (!mem_pend && $urandom_range(0, 99) < 35) begin
            mem_pend = 1'b1; mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
            mem_addr = rand_addr(); mem_wdata = $urandom;
        end
    endtask

    initial begin
        int mem_ack_at, if_ack_at, mem_acks, if_acks, mem_before_if;

        // Reset state
        repeat (2) @(negedge clk);
        check_bit("reset_ram_en", ram_en, 1'b0);
        check_bit("reset_ram_we", ram_we, 1'b0);
        check_bit("reset_if_ack", if_ack, 1'b0);
        check_bit("reset_mem_ack", mem_ack, 1'b0);
        check_word("reset_if_rdata", if_rdata, 32'h0);
        check_word("reset_mem_rdata", mem_rdata, 32'h0);
        check_word("reset_ram_addr", ram_addr, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Lone fetch from 0x10
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check_bit("fetch_en_c1", ram_en, 1'b1);
        check_word("fetch_addr_c1", ram_addr, 32'h10);
        check_bit("fetch_stall_c1", stall_if, 1'b1);
        @(negedge clk);
        check_bit("fetch_en_c2", ram_en, 1'b1);
        check_bit("fetch_ack_c2", if_ack, 1'b0);
        @(negedge clk);
        check_bit("fetch_en_c3", ram_en, 1'b0);
        check_bit("fetch_ack_c3", if_ack, 1'b1);
        check_word("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        check_bit("fetch_stall_c3", stall_if, 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        check_bit("fetch_ack_c4", if_ack, 1'b0);
        check_word("fetch_rdata_held", if_rdata, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);

        // Store of 0x12345678 to 0x20
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h1234_5678;
        @(negedge clk);
        check_bit("store_we_c1", ram_we, 1'b1);
        check_word("store_wdata_c1", ram_wdata, 32'h1234_5678);
        @(negedge clk);
        check_bit("store_we_c2", ram_we, 1'b1);
        @(negedge clk);
        check_bit("store_we_c3", ram_we, 1'b0);
        check_bit("store_ack", mem_ack, 1'b1);
        check_word("store_rdata_unchanged", mem_rdata, 32'h0);
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        check_bit("store_ack_once", mem_ack, 1'b0);
        repeat (2) @(negedge clk);

        // Collision: both requests rise together, MEM load 0x20, IF 0x40
        mem_req = 1'b1; mem_addr = 32'h20; if_req = 1'b1; if_addr = 32'h40;
        mem_ack_at = 0; if_ack_at = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_ack && mem_ack_at == 0) mem_ack_at = k;
            if (if_ack && if_ack_at == 0) if_ack_at = k;
            if (if_ack_at == 0) check_bit("collision_stall_if", stall_if, 1'b1);
            if (mem_ack) mem_req = 1'b0;
            if (if_ack) if_req = 1'b0;
        end
        check_word("collision_mem_ack_cycle", 32'(mem_ack_at), 32'd3);
        check_word("collision_if_ack_cycle", 32'(if_ack_at), 32'd7);
        check_word("collision_load_data", mem_rdata, 32'h1234_5678);
        mem_req = 1'b0; if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of an access
        if_req = 1'b1; if_addr = 32'h50;
        @(negedge clk);
        check_bit("abort_en_before", ram_en, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_bit("abort_en_now", ram_en, 1'b0);
        check_bit("abort_if_ack", if_ack, 1'b0);
        check_bit("abort_mem_ack", mem_ack, 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_word("abort_if_rdata", if_rdata, 32'h0);
        check_word("abort_mem_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        check_bit("abort_idle", ram_en, 1'b0);
        check_bit("abort_no_ack", if_ack, 1'b0);

        // Starvation: both requests held, MEM requests back to back
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8; if_req = 1'b1; if_addr = 32'h10;
        mem_acks = 0; if_acks = 0; mem_before_if = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (if_ack) begin
                if_acks++;
                if (mem_before_if < 0) mem_before_if = mem_acks;
                if_req = 1'b0;
            end
            if (mem_ack) mem_acks++;
        end
        mem_req = 1'b0; if_req = 1'b0;
        if (GUARD) begin
            check_word("starve_if_granted", 32'(if_acks), 32'd1);
            check_word("starve_mem_before_if", 32'(mem_before_if), 32'd2);
        end else begin
            check_word("starve_if_never", 32'(if_acks), 32'd0);
            check_word("starve_mem_acks", 32'(mem_acks), 32'd10);
        end
        repeat (3) @(negedge clk);

        // LATENCY=1 load from 0x4 on the second instance
        d1_mem_req = 1'b1; d1_mem_addr = 32'h4;
        @(negedge clk);
        check_bit("lat1_en_c1", d1_ram_en, 1'b1);
        check_bit("lat1_ack_c1", d1_mem_ack, 1'b0);
        @(negedge clk);
        check_bit("lat1_ack_c2", d1_mem_ack, 1'b1);
        check_word("lat1_rdata", d1_mem_rdata, 32'h5);
        check_bit("lat1_en_c2", d1_ram_en, 1'b0);
        d1_mem_req = 1'b0;
        @(negedge clk);
        check_bit("lat1_ack_c3", d1_mem_ack, 1'b0);

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            apply_stimulus();
        end
        if_req = 1'b0; mem_req = 1'b0;
        repeat (8) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
